mips16_id_stage: RTL and testbench

Instruction-decode stage of the 16-bit MIPS pipeline. Takes the fetched instruction from IF, decodes opcode_t, and reads the 8x16 register file, which has a write-back port and same-cycle bypass. Detects load-use hazards and stalls IF. Registers the decoded operands and control into the ID/EX pipeline register consumed by EX.

---
 rtl/mips16_id_stage_pkg.sv | 73 +++++++
 rtl/mips16_regfile.sv | 48 ++++
 rtl/mips16_id_stage.sv | 113 +++++++++++
 tb/tb_mips16_id_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_id_stage_pkg.sv
// Shared definitions for the 16-bit MIPS decode stage: instruction field
// positions, the opcode map and the ID/EX pipeline register layout.
package mips16_id_stage_pkg;

    localparam int PC_W       = 8;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;
    localparam int INSTR_W    = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 6;

    // 0x1..0x8 are the R-type ALU group; 0xD..0xF are unassigned.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SLT   = 4'h6,
        OP_SLL   = 4'h7,
        OP_SRU   = 4'h8,
        OP_ADDI  = 4'h9,
        OP_LD    = 4'hA,
        OP_ST    = 4'hB,
        OP_BZ    = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_ILL_F = 4'hF
    } opcode_t;

    typedef struct packed {
        logic                  valid;
        opcode_t               op;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     rs1_data;
        logic [DATA_W-1:0]     rs2_data;
        logic [DATA_W-1:0]     imm;
        logic [PC_W-1:0]       pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
    } id_ex_t;

    function automatic logic is_r_type(opcode_t op);
        return (op >= OP_ADD) && (op <= OP_SRU);
    endfunction

    function automatic logic is_illegal(opcode_t op);
        return op >= OP_ILL_D;
    endfunction

    function automatic logic uses_rs1(opcode_t op);
        return (op != OP_NOP) && !is_illegal(op);
    endfunction

    // ST reads its data register on the second port as well.
    function automatic logic uses_rs2(opcode_t op);
        return is_r_type(op) || (op == OP_ST);
    endfunction

    function automatic logic writes_rd(opcode_t op);
        return is_r_type(op) || (op == OP_ADDI) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/mips16_regfile.sv
// 8x16 register file: two combinational read ports with write-back bypass,
// one write port, R0 hardwired to zero.
module mips16_regfile
    import mips16_id_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // A write landing this cycle is visible to the reader immediately.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/mips16_id_stage.sv
// Decode stage: field decode, register read with bypass, load-use stall
// detection and the ID/EX pipeline register.
module mips16_id_stage
    import mips16_id_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [INSTR_W-1:0]    if_instr,
    input  logic [PC_W-1:0]       if_pc,
    input  logic                  flush,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [OP_W-1:0]       ex_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_rs1_data,
    output logic [DATA_W-1:0]     ex_rs2_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [PC_W-1:0]       ex_pc,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_illegal
);

    opcode_t               op;
    logic [REG_ADDR_W-1:0] f_rd;
    logic [REG_ADDR_W-1:0] f_rs1;
    logic [REG_ADDR_W-1:0] f_rs2;
    logic [IMM_W-1:0]      f_imm;
    logic [REG_ADDR_W-1:0] src_b;
    logic                  use_a;
    logic                  use_b;
    logic [DATA_W-1:0]     rdata_a;
    logic [DATA_W-1:0]     rdata_b;
    logic                  hit_a;
    logic                  hit_b;
    id_ex_t                issue;
    id_ex_t                ex_q;

    assign op    = opcode_t'(if_instr[OP_MSB -: OP_W]);
    assign f_rd  = if_instr[RD_LSB +: REG_ADDR_W];
    assign f_rs1 = if_instr[RS1_LSB +: REG_ADDR_W];
    assign f_rs2 = if_instr[RS2_LSB +: REG_ADDR_W];
    assign f_imm = if_instr[IMM_W-1:0];

    // ST's data register sits in the rd field but is read on port B.
    assign src_b = is_r_type(op) ? f_rs2 : f_rd;
    assign use_a = uses_rs1(op);
    assign use_b = uses_rs2(op);

    mips16_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (f_rs1),
        .rdata_a (rdata_a),
        .raddr_b (src_b),
        .rdata_b (rdata_b)
    );

    assign hit_a = use_a && (ex_q.rd == f_rs1);
    assign hit_b = use_b && (ex_q.rd == src_b);

    assign id_stall = if_valid && ex_q.valid && (ex_q.op == OP_LD)
                    && (ex_q.rd != '0) && (hit_a || hit_b)
                    && !flush && !rst;

    always_comb begin
        issue          = '0;
        issue.valid    = 1'b1;
        issue.pc       = if_pc;
        issue.imm      = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
        issue.illegal  = is_illegal(op);
        issue.op       = is_illegal(op) ? OP_NOP : op;
        issue.rs1_data = use_a ? rdata_a : '0;
        issue.rs2_data = use_b ? rdata_b : '0;
        if (writes_rd(op)) begin
            issue.rd        = f_rd;
            issue.reg_write = (f_rd != '0);
        end
        issue.mem_read  = (op == OP_LD);
        issue.mem_write = (op == OP_ST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush || id_stall || !if_valid) begin
            ex_q <= '0;
        end else begin
            ex_q <= issue;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_op        = ex_q.op;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_pc        = ex_q.pc;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_mips16_id_stage.sv
// Directed plus randomized check of the decode stage against an
// instruction-level reference model held in the bench.
module tb_mips16_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [7:0]  if_pc = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        id_stall;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_rs1_data;
    logic [15:0] ex_rs2_data;
    logic [15:0] ex_imm;
    logic [7:0]  ex_pc;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;

    int total = 0;
    int bad = 0;

    int m_regs [8];
    int m_ex [11];
    int n_ex [11];
    int last_stall;

    mips16_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush        (flush),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_rd        (ex_rd),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_pc        (ex_pc),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_illegal   (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register read as the architecture defines it: R0 is zero, and a
    // write-back happening this cycle is already visible.
    function automatic int rd_reg(input int a);
        if (a == 0) return 0;
        if (wb_we && int'(wb_addr) == a) return int'(wb_data);
        return m_regs[a];
    endfunction

    // Slot order: valid op rd rs1 rs2 imm pc reg_write mem_read mem_write illegal
    task automatic model_step(output int stall);
        int op, rd, rs1, rs2, imm6, srcb;
        bit rtype, ua, ub, ill, wr;
        stall = 0;
        foreach (n_ex[i]) n_ex[i] = 0;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            return;
        end
        op    = int'(if_instr) / 4096;
        rd    = (int'(if_instr) / 512) % 8;
        rs1   = (int'(if_instr) / 64) % 8;
        rs2   = (int'(if_instr) / 8) % 8;
        imm6  = int'(if_instr) % 64;
        rtype = (op >= 1 && op <= 8);
        ill   = (op >= 13);
        ua    = (op >= 1 && op <= 12);
        ub    = rtype || op == 11;
        srcb  = rtype ? rs2 : rd;
        wr    = rtype || op == 9 || op == 10;
        if (if_valid && m_ex[0] == 1 && m_ex[1] == 10 && m_ex[2] != 0 && !flush
            && ((ua && m_ex[2] == rs1) || (ub && m_ex[2] == srcb)))
            stall = 1;
        if (if_valid && !flush && !stall) begin
            n_ex[0]  = 1;
            n_ex[1]  = ill ? 0 : op;
            n_ex[2]  = wr ? rd : 0;
            n_ex[3]  = ua ? rd_reg(rs1) : 0;
            n_ex[4]  = ub ? rd_reg(srcb) : 0;
            n_ex[5]  = (imm6 >= 32) ? imm6 - 64 + 65536 : imm6;
            n_ex[6]  = int'(if_pc);
            n_ex[7]  = (wr && rd != 0) ? 1 : 0;
            n_ex[8]  = (op == 10) ? 1 : 0;
            n_ex[9]  = (op == 11) ? 1 : 0;
            n_ex[10] = ill ? 1 : 0;
        end
        if (wb_we && wb_addr != 0) m_regs[wb_addr] = int'(wb_data);
    endtask

    task automatic cyc(input bit v, input logic [15:0] ins, input logic [7:0] pc,
                       input bit fl, input bit we, input logic [2:0] wa,
                       input logic [15:0] wd);
        int e_stall;
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        model_step(e_stall);
        chk("id_stall", int'(id_stall), e_stall);
        last_stall = int'(id_stall);
        @(posedge clk);
        #1;
        m_ex = n_ex;
        chk("ex_valid", int'(ex_valid), m_ex[0]);
        chk("ex_op", int'(ex_op), m_ex[1]);
        chk("ex_rd", int'(ex_rd), m_ex[2]);
        chk("ex_rs1_data", int'(ex_rs1_data), m_ex[3]);
        chk("ex_rs2_data", int'(ex_rs2_data), m_ex[4]);
        chk("ex_imm", int'(ex_imm), m_ex[5]);
        chk("ex_pc", int'(ex_pc), m_ex[6]);
        chk("ex_reg_write", int'(ex_reg_write), m_ex[7]);
        chk("ex_mem_read", int'(ex_mem_read), m_ex[8]);
        chk("ex_mem_write", int'(ex_mem_write), m_ex[9]);
        chk("ex_illegal", int'(ex_illegal), m_ex[10]);
    endtask

    initial begin
        logic [15:0] ins;
        logic [7:0]  pc;
        int          opsel;
        foreach (m_regs[i]) m_regs[i] = 0;
        foreach (m_ex[i]) m_ex[i] = 0;
        last_stall = 0;

        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 16'h1650, 8'h00, 0, 1, 3'd1, 16'h5555);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 16'h0000, 8'h00, 0, 0, 3'd0, 16'h0);

        // R1=5, R2=3, then ADD R3,R1,R2
        cyc(0, 16'h0000, 8'h00, 0, 1, 3'd1, 16'h0005);
        cyc(0, 16'h0000, 8'h00, 0, 1, 3'd2, 16'h0003);
        cyc(1, 16'h1650, 8'h10, 0, 0, 3'd0, 16'h0);
        chk("add_valid", int'(ex_valid), 1);
        chk("add_rs1", int'(ex_rs1_data), 5);
        chk("add_rs2", int'(ex_rs2_data), 3);
        chk("add_rd", int'(ex_rd), 3);

        // ADDI R4,R1,-1 with a same-cycle write-back to R1
        cyc(1, 16'h987F, 8'h11, 0, 1, 3'd1, 16'h00AA);
        chk("addi_bypass", int'(ex_rs1_data), 16'h00AA);
        chk("addi_imm", int'(ex_imm), 16'hFFFF);

        // LD R2,0(R1) then ADD R3,R2,R2: one stall, then bypassed issue
        cyc(1, 16'hA440, 8'h12, 0, 0, 3'd0, 16'h0);
        cyc(1, 16'h1690, 8'h13, 0, 0, 3'd0, 16'h0);
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble", int'(ex_valid), 0);
        cyc(1, 16'h1690, 8'h13, 0, 1, 3'd2, 16'h0077);
        chk("lu_release", last_stall, 0);
        chk("lu_rs2", int'(ex_rs2_data), 16'h0077);

        // flush while a load-use condition is present
        cyc(1, 16'hA440, 8'h20, 0, 0, 3'd0, 16'h0);
        cyc(1, 16'h1690, 8'h21, 1, 0, 3'd0, 16'h0);
        chk("flush_stall", last_stall, 0);
        chk("flush_valid", int'(ex_valid), 0);

        // writes to R0 are dropped, even with a same-cycle read
        cyc(1, 16'h9A01, 8'h30, 0, 1, 3'd0, 16'h1234);
        chk("r0_bypass", int'(ex_rs1_data), 0);
        cyc(1, 16'h9A01, 8'h31, 0, 0, 3'd0, 16'h0);
        chk("r0_read", int'(ex_rs1_data), 0);

        cyc(1, 16'hF000, 8'h32, 0, 0, 3'd0, 16'h0);
        chk("ill_flag", int'(ex_illegal), 1);
        chk("ill_op", int'(ex_op), 0);

        // reset arriving while a load-use stall is pending
        cyc(1, 16'hA440, 8'h40, 0, 0, 3'd0, 16'h0);
        rst = 1'b1;
        cyc(1, 16'h1690, 8'h41, 0, 0, 3'd0, 16'h0);
        rst = 1'b0;
        chk("rst_stall", last_stall, 0);
        cyc(1, 16'h1690, 8'h41, 0, 0, 3'd0, 16'h0);
        chk("rst_regs", int'(ex_rs2_data), 0);

        ins = '0;
        pc  = '0;
        for (int n = 0; n < 400; n++) begin
            bit v, fl, we;
            if (last_stall == 0) begin
                opsel = int'($urandom_range(0, 9));
                ins = 16'($urandom);
                if (opsel < 3) ins[15:12] = 4'hA;
                pc = 8'($urandom);
                v  = ($urandom_range(0, 99) < 85);
            end else begin
                v = 1'b1;
            end
            fl = ($urandom_range(0, 99) < 8);
            we = ($urandom_range(0, 99) < 50);
            cyc(v, ins, pc, fl, we, 3'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
